// File: rtl/led_matrix_scanner.sv
// Double-buffered 8x8 LED frame buffer with a registered row-scanning driver.
// Optional macro BRIGHTNESS_EN adds a bright[2:0] port that shortens the lit part of each row.
module led_matrix_scanner #(
   parameter int DWELL_CYCLES = 25000,
   parameter int BLANK_CYCLES = 16,
   parameter int CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [2:0] wr_x,
   input  logic [2:0] wr_y,
   input  logic       wr_val,
   input  logic       frame_done,
`ifdef BRIGHTNESS_EN
   input  logic [2:0] bright,
`endif
   output logic       busy,
   output logic       swap_ack,
   output logic       frame_start,
   output logic [7:0] Ox,
   output logic [7:0] Oy
);

   localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES);

`ifdef BRIGHTNESS_EN
   function automatic logic [CNT_W:0] calc_lit_len(input logic [2:0] level);
      logic [31:0] span;
      span = ((32'(level) + 32'd1) * 32'(DWELL_CYCLES - BLANK_CYCLES)) >> 3;
      return (CNT_W+1)'(span);
   endfunction

   logic [CNT_W:0] lit_len_p1, lit_len_p0;
`endif

   // both buffers in one array; sel_p1 names the one being scanned
   logic [1:0][7:0][7:0] fb_p1, fb_p0;
   logic                 sel_p1, sel_p0;
   logic [2:0]           row_p1, row_p0;
   logic [CNT_W-1:0]     phase_p1, phase_p0;
   logic                 pending_p1, pending_p0;
   logic                 end_of_row, end_of_frame, swap, lit_p0;
   logic [7:0]           ox_p0, oy_p0, ox_p1, oy_p1;
   logic                 ack_p1, fs_p1;

   // stage 0: next scan position, buffer contents and the outputs they imply
   always_comb begin
      end_of_row   = (phase_p1 == PHASE_LAST);
      end_of_frame = end_of_row && (row_p1 == 3'd7);
      swap         = pending_p1 && end_of_frame;
      phase_p0     = end_of_row ? '0 : phase_p1 + 1'b1;
      row_p0       = end_of_row ? row_p1 + 3'd1 : row_p1;
      sel_p0       = sel_p1 ^ swap;
      pending_p0   = swap ? frame_done : (pending_p1 | frame_done);

      // a write in the swap cycle lands before the buffers trade places
      fb_p0 = fb_p1;
      if (wr_en)
         fb_p0[~sel_p1][wr_y][wr_x] = wr_val;
      if (swap)
         fb_p0[sel_p1] = '0;

`ifdef BRIGHTNESS_EN
      lit_len_p0 = end_of_frame ? calc_lit_len(bright) : lit_len_p1;
      lit_p0 = (phase_p0 >= BLANK_END) &&
               ({1'b0, phase_p0} < ({1'b0, BLANK_END} + lit_len_p0));
`else
      lit_p0 = (phase_p0 >= BLANK_END);
`endif

      ox_p0 = lit_p0 ? fb_p0[sel_p0][row_p0] : 8'h00;
      oy_p0 = lit_p0 ? (8'd1 << row_p0) : 8'h00;
   end

   // stage 1: registered state and outputs
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         fb_p1      <= '0;
         sel_p1     <= 1'b0;
         row_p1     <= 3'd0;
         phase_p1   <= '0;
         pending_p1 <= 1'b0;
         ox_p1      <= 8'h00;
         oy_p1      <= 8'h00;
         ack_p1     <= 1'b0;
         fs_p1      <= 1'b0;
`ifdef BRIGHTNESS_EN
         lit_len_p1 <= calc_lit_len(3'd7);
`endif
      end else begin
         fb_p1      <= fb_p0;
         sel_p1     <= sel_p0;
         row_p1     <= row_p0;
         phase_p1   <= phase_p0;
         pending_p1 <= pending_p0;
         ox_p1      <= ox_p0;
         oy_p1      <= oy_p0;
         ack_p1     <= swap;
         fs_p1      <= end_of_frame;
`ifdef BRIGHTNESS_EN
         lit_len_p1 <= lit_len_p0;
`endif
      end
   end

   assign busy        = pending_p1;
   assign swap_ack    = ack_p1;
   assign frame_start = fs_p1;
   assign Ox          = ox_p1;
   assign Oy          = oy_p1;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomised bench for led_matrix_scanner: cycle-count based reference model plus literal pins.
module tb_led_matrix_scanner;

   localparam int D     = 10;
   localparam int B     = 2;
   localparam int FRAME = 8 * D;

   logic       sysclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_x = 3'd0;
   logic [2:0] wr_y = 3'd0;
   logic       wr_val = 1'b0;
   logic       frame_done = 1'b0;
`ifdef BRIGHTNESS_EN
   logic [2:0] bright = 3'd7;
`endif
   logic       busy, swap_ack, frame_start;
   logic [7:0] Ox, Oy;

   int n_checks = 0;
   int n_pass = 0;

   led_matrix_scanner #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .sysclk(sysclk), .rst_n(rst_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
      .wr_val(wr_val), .frame_done(frame_done),
`ifdef BRIGHTNESS_EN
      .bright(bright),
`endif
      .busy(busy), .swap_ack(swap_ack), .frame_start(frame_start), .Ox(Ox), .Oy(Oy)
   );

   always #5 sysclk = ~sysclk;

   // reference model: position derived from cycles since reset release
   int         m_t;
   logic [7:0] m_front [8];
   logic [7:0] m_back  [8];
   bit         m_pending, m_ack, m_fs;
   logic [7:0] m_ox, m_oy;
   int         m_lit_len;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, m_t);
   endtask

   task automatic model_reset();
      m_t = 0;
      for (int i = 0; i < 8; i++) begin
         m_front[i] = 8'h00;
         m_back[i]  = 8'h00;
      end
      m_pending = 0; m_ack = 0; m_fs = 0;
      m_ox = 8'h00; m_oy = 8'h00;
      m_lit_len = D - B;
   endtask

   task automatic model_edge();
      int row, ph;
      bit eof, lit;
      row = (m_t / D) % 8;
      ph  = m_t % D;
      eof = (row == 7) && (ph == D - 1);
      m_ack = m_pending && eof;
      if (wr_en) m_back[wr_y][wr_x] = wr_val;
      if (m_ack) begin
         m_front = m_back;
         for (int i = 0; i < 8; i++) m_back[i] = 8'h00;
         m_pending = frame_done;
      end else begin
         m_pending = m_pending | frame_done;
      end
      m_fs = eof;
`ifdef BRIGHTNESS_EN
      if (eof) m_lit_len = ((int'(bright) + 1) * (D - B)) / 8;
`endif
      m_t++;
      row = (m_t / D) % 8;
      ph  = m_t % D;
      lit = (ph >= B) && (ph < B + m_lit_len);
      m_ox = lit ? m_front[row] : 8'h00;
      m_oy = lit ? 8'(1 << row) : 8'h00;
   endtask

   // compare process: every edge and every reset assertion
   initial begin
      model_reset();
      forever begin
         @(posedge sysclk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_edge();
         #1;
         check("Ox", {24'd0, Ox}, {24'd0, m_ox});
         check("Oy", {24'd0, Oy}, {24'd0, m_oy});
         check("busy", {31'd0, busy}, {31'd0, m_pending});
         check("swap_ack", {31'd0, swap_ack}, {31'd0, m_ack});
         check("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge sysclk);
   endtask

   task automatic wait_t(input int target);
      int guard = 0;
      while (m_t != target && guard < 2000) begin
         tick();
         guard++;
      end
      if (m_t != target) check("wait_t", m_t, target);
   endtask

   task automatic wait_phase(input int row, input int ph);
      int guard = 0;
      while ((m_t % FRAME) != row * D + ph && guard < FRAME + 2) begin
         tick();
         guard++;
      end
      if ((m_t % FRAME) != row * D + ph) check("wait_phase", m_t % FRAME, row * D + ph);
   endtask

   task automatic write_px(input int x, input int y, input bit v);
      wr_en = 1'b1; wr_x = 3'(x); wr_y = 3'(y); wr_val = v;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_done();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
   endtask

   initial begin
      int acks;
      logic [7:0] ox_or;

      // reset and empty scan
      repeat (3) tick();
      check("rst_Ox", Ox, 0);
      check("rst_Oy", Oy, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_t(1);  check("t1_Oy", Oy, 8'h00);
      wait_t(2);  check("t2_Oy", Oy, 8'h01); check("t2_Ox", Ox, 8'h00);
      wait_t(9);  check("t9_Oy", Oy, 8'h01);
      wait_t(10); check("t10_Oy", Oy, 8'h00);
      wait_t(12); check("t12_Oy", Oy, 8'h02);
      wait_t(79); check("t79_fs", frame_start, 0);
      wait_t(80); check("t80_fs", frame_start, 1);
      wait_t(81); check("t81_fs", frame_start, 0);

      // two pixels in row 2 then swap
      write_px(3, 2, 1);
      write_px(7, 2, 1);
      pulse_done();
      check("busy_after_done", busy, 1);
      wait_t(159); check("t159_ack", swap_ack, 0);
      wait_t(160); check("t160_ack", swap_ack, 1); check("t160_busy", busy, 0);
      wait_t(172); check("row1_Ox", Ox, 8'h00); check("row1_Oy", Oy, 8'h02);
      wait_t(182); check("row2_Ox", Ox, 8'h88); check("row2_Oy", Oy, 8'h04);

      // writes without frame_done for three frames
      acks = 0;
      repeat (3 * FRAME) begin
         if ($urandom_range(3) == 0) begin
            wr_en = 1'b1; wr_x = 3'($urandom); wr_y = 3'($urandom); wr_val = 1'($urandom);
         end else begin
            wr_en = 1'b0;
         end
         tick();
         acks += int'(swap_ack);
      end
      wr_en = 1'b0;
      check("no_swap_acks", acks, 0);
      check("no_swap_busy", busy, 0);
      wait_phase(2, 2); check("still_88", Ox, 8'h88);

      // merged frame_done pulses give one swap
      wait_phase(0, 5); pulse_done();
      wait_phase(2, 0); pulse_done();
      wait_phase(5, 0); pulse_done();
      acks = 0;
      repeat (FRAME) begin
         tick();
         acks += int'(swap_ack);
      end
      check("merged_acks", acks, 1);
      pulse_done();
      wait_phase(0, 0);
      check("blank_swap_ack", swap_ack, 1);
      ox_or = 8'h00;
      repeat (FRAME) begin
         tick();
         ox_or |= Ox;
      end
      check("blank_frame", ox_or, 8'h00);

      // write and frame_done in the swap cycle itself
      pulse_done();
      wait_phase(7, 9);
      wr_en = 1'b1; wr_x = 3'd0; wr_y = 3'd0; wr_val = 1'b1; frame_done = 1'b1;
      tick();
      wr_en = 1'b0; frame_done = 1'b0;
      check("edge_ack", swap_ack, 1);
      check("edge_rearm", busy, 1);
      wait_phase(0, 2); check("edge_Ox", Ox, 8'h01); check("edge_Oy", Oy, 8'h01);

      // random traffic
      repeat (1500) begin
         wr_en = ($urandom_range(2) == 0);
         wr_x = 3'($urandom); wr_y = 3'($urandom); wr_val = 1'($urandom);
         frame_done = ($urandom_range(99) == 0);
`ifdef BRIGHTNESS_EN
         if ($urandom_range(49) == 0) bright = 3'($urandom);
`endif
         tick();
      end
      wr_en = 1'b0; frame_done = 1'b0;
`ifdef BRIGHTNESS_EN
      bright = 3'd7;
      wait_phase(0, 1);
`endif

      // asynchronous reset mid-row
      pulse_done();
      wait_phase(5, 6);
      check("pre_rst_Oy", Oy, 8'h20);
      #2 rst_n = 1'b0;
      #1;
      check("async_Ox", Ox, 0);
      check("async_Oy", Oy, 0);
      check("async_busy", busy, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      wait_t(2);  check("rst2_Oy", Oy, 8'h01); check("rst2_Ox", Ox, 8'h00);
      wait_t(42); check("rst42_Oy", Oy, 8'h10); check("rst42_Ox", Ox, 8'h00);
      check("rst42_busy", busy, 0);

`ifdef BRIGHTNESS_EN
      // reduced duty: lit_len 4 -> phases 2..5
      bright = 3'd3;
      wait_phase(0, 0);
      wait_phase(1, 1); check("br_p1", Oy, 8'h00);
      wait_phase(1, 2); check("br_p2", Oy, 8'h02);
      wait_phase(1, 5); check("br_p5", Oy, 8'h02);
      wait_phase(1, 6); check("br_p6", Oy, 8'h00);
`endif

      repeat (FRAME) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
